// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: two 1-entry holding slots (ALU path A, load/multi-cycle path B)
// share one register-file write port, with a pending-destination mask for the issue stage.
module wb_port_arbiter #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit RR_EN      = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         a_valid_i,
    output logic                         a_ready_o,
    input  logic [REG_ADDR_W-1:0]        a_rd_i,
    input  logic [XLEN-1:0]              a_data_i,
    input  logic                         b_valid_i,
    output logic                         b_ready_o,
    input  logic [REG_ADDR_W-1:0]        b_rd_i,
    input  logic [XLEN-1:0]              b_data_i,
    output logic                         wr_en_o,
    output logic [REG_ADDR_W-1:0]        wr_rd_o,
    output logic [XLEN-1:0]              wr_data_o,
    output logic [(1<<REG_ADDR_W)-1:0]   pend_mask_o
);

    logic                  a_full_q, a_full_d;
    logic                  b_full_q, b_full_d;
    logic                  last_grant_q, last_grant_d;
    logic [REG_ADDR_W-1:0] a_rd_q, b_rd_q;
    logic [XLEN-1:0]       a_data_q, b_data_q;
    logic                  grant_a, grant_b;
    logic                  a_load, b_load;

    // Grant depends only on slot state, so no valid-to-output combinational path exists.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_full_q && b_full_q) begin
            if (RR_EN) begin
                grant_a = last_grant_q;
                grant_b = !last_grant_q;
            end else begin
                grant_a = 1'b1;
            end
        end else if (a_full_q) begin
            grant_a = 1'b1;
        end else if (b_full_q) begin
            grant_b = 1'b1;
        end
    end

    assign a_ready_o = !a_full_q || grant_a;
    assign b_ready_o = !b_full_q || grant_b;
    assign a_load    = a_valid_i && a_ready_o;
    assign b_load    = b_valid_i && b_ready_o;

    always_comb begin
        wr_rd_o   = '0;
        wr_data_o = '0;
        if (grant_a) begin
            wr_rd_o   = a_rd_q;
            wr_data_o = a_data_q;
        end else if (grant_b) begin
            wr_rd_o   = b_rd_q;
            wr_data_o = b_data_q;
        end
    end

    // x0 entries still take their grant cycle but never reach the regfile.
    assign wr_en_o = (grant_a || grant_b) && (wr_rd_o != '0);

    always_comb begin
        pend_mask_o = '0;
        if (a_full_q) pend_mask_o[a_rd_q] = 1'b1;
        if (b_full_q) pend_mask_o[b_rd_q] = 1'b1;
        pend_mask_o[0] = 1'b0;
    end

    always_comb begin
        a_full_d     = a_full_q;
        b_full_d     = b_full_q;
        last_grant_d = last_grant_q;
        if (grant_a) begin
            a_full_d     = 1'b0;
            last_grant_d = 1'b0;
        end
        if (grant_b) begin
            b_full_d     = 1'b0;
            last_grant_d = 1'b1;
        end
        // A new load wins over the clear so a lone source streams at one write per cycle.
        if (a_load) a_full_d = 1'b1;
        if (b_load) b_full_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_full_q     <= 1'b0;
            b_full_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            a_full_q     <= a_full_d;
            b_full_q     <= b_full_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Slot payload is qualified by the full flags, so it needs no reset.
    always_ff @(posedge clk) begin
        if (a_load) begin
            a_rd_q   <= a_rd_i;
            a_data_q <= a_data_i;
        end
        if (b_load) begin
            b_rd_q   <= b_rd_i;
            b_data_q <= b_data_i;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: one round-robin and one fixed-priority instance,
// cycle tables for contention plus directed sequences with a write scoreboard.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        av[2], bv[2], ar[2], br[2], wen[2];
    logic [4:0]  ard[2], brd[2], wrd[2];
    logic [31:0] adata[2], bdata[2], wdata[2], pend[2];

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.XLEN(32), .REG_ADDR_W(5), .RR_EN(1'b1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .a_valid_i(av[0]), .a_ready_o(ar[0]), .a_rd_i(ard[0]), .a_data_i(adata[0]),
        .b_valid_i(bv[0]), .b_ready_o(br[0]), .b_rd_i(brd[0]), .b_data_i(bdata[0]),
        .wr_en_o(wen[0]), .wr_rd_o(wrd[0]), .wr_data_o(wdata[0]), .pend_mask_o(pend[0])
    );

    wb_port_arbiter #(.XLEN(32), .REG_ADDR_W(5), .RR_EN(1'b0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .a_valid_i(av[1]), .a_ready_o(ar[1]), .a_rd_i(ard[1]), .a_data_i(adata[1]),
        .b_valid_i(bv[1]), .b_ready_o(br[1]), .b_rd_i(brd[1]), .b_data_i(bdata[1]),
        .wr_en_o(wen[1]), .wr_rd_o(wrd[1]), .wr_data_o(wdata[1]), .pend_mask_o(pend[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic        bv;
        logic [4:0]  brd;
        logic        ear;
        logic        ebr;
        logic        ewen;
        logic [4:0]  erd;
        logic [31:0] epend;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    vec_t rr_tab[10];
    vec_t fp_tab[10];
    wr_t  sbq[$];

    // Source A data is 0xA0+rd, source B data is 0xB0+rd; table rds 1..4 are A, 9..12 are B.
    function automatic vec_t mk(input logic av_, input logic [4:0] ard_, input logic bv_,
                                input logic [4:0] brd_, input logic ear_, input logic ebr_,
                                input logic ewen_, input logic [4:0] erd_, input logic [31:0] ep_);
        vec_t v;
        v.av = av_; v.ard = ard_; v.bv = bv_; v.brd = brd_;
        v.ear = ear_; v.ebr = ebr_; v.ewen = ewen_; v.erd = erd_; v.epend = ep_;
        return v;
    endfunction

    function automatic logic [31:0] exp_data(input logic ewen_, input logic [4:0] erd_);
        if (!ewen_) return 32'h0;
        return (erd_ <= 5'd4) ? (32'hA0 + {27'b0, erd_}) : (32'hB0 + {27'b0, erd_});
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle_all();
        for (int d = 0; d < 2; d++) begin
            av[d] = 1'b0; bv[d] = 1'b0; ard[d] = '0; brd[d] = '0;
            adata[d] = '0; bdata[d] = '0;
        end
    endtask

    task automatic drive_row(input int d, input vec_t v);
        av[d]    = v.av;
        ard[d]   = v.ard;
        adata[d] = 32'hA0 + {27'b0, v.ard};
        bv[d]    = v.bv;
        brd[d]   = v.brd;
        bdata[d] = 32'hB0 + {27'b0, v.brd};
    endtask

    task automatic check_row(input int d, input vec_t v, input int i);
        chk($sformatf("tab%0d_c%0d_a_ready", d, i), ar[d], v.ear);
        chk($sformatf("tab%0d_c%0d_b_ready", d, i), br[d], v.ebr);
        chk($sformatf("tab%0d_c%0d_wr_en", d, i), wen[d], v.ewen);
        chk($sformatf("tab%0d_c%0d_wr_rd", d, i), wrd[d], v.ewen ? v.erd : 5'd0);
        chk($sformatf("tab%0d_c%0d_wr_data", d, i), wdata[d], exp_data(v.ewen, v.erd));
        chk($sformatf("tab%0d_c%0d_pend", d, i), pend[d], v.epend);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input int d);
        for (int i = 0; i < 10; i++) begin
            vec_t v;
            v = (d == 0) ? rr_tab[i] : fp_tab[i];
            drive_row(d, v);
            @(negedge clk);
            check_row(d, v, i);
            next_cycle();
        end
        idle_all();
    endtask

    // Pops the scoreboard whenever the selected instance writes.
    task automatic sb_check(input int d, output logic wrote);
        wr_t e;
        wrote = wen[d];
        if (wen[d]) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_write", wrd[d], 5'd0);
            end else begin
                e = sbq.pop_front();
                chk("sb_wr_rd", wrd[d], e.rd);
                chk("sb_wr_data", wdata[d], e.data);
            end
        end
    endtask

    initial begin
        logic [4:0]  lone_rd[3];
        logic [31:0] lone_dat[3];
        logic        wrote;
        int          nwr, first_wr, last_wr;

        // Cycle tables: contention, round-robin (u_rr) and fixed priority (u_fp).
        rr_tab[0] = mk(1, 1, 1,  9, 1, 1, 0,  0, 32'h0);
        rr_tab[1] = mk(1, 2, 1, 10, 1, 0, 1,  1, 32'h202);
        rr_tab[2] = mk(1, 3, 1, 10, 0, 1, 1,  9, 32'h204);
        rr_tab[3] = mk(1, 3, 1, 11, 1, 0, 1,  2, 32'h404);
        rr_tab[4] = mk(1, 4, 1, 11, 0, 1, 1, 10, 32'h408);
        rr_tab[5] = mk(1, 4, 1, 12, 1, 0, 1,  3, 32'h808);
        rr_tab[6] = mk(0, 0, 1, 12, 0, 1, 1, 11, 32'h810);
        rr_tab[7] = mk(0, 0, 0,  0, 1, 0, 1,  4, 32'h1010);
        rr_tab[8] = mk(0, 0, 0,  0, 1, 1, 1, 12, 32'h1000);
        rr_tab[9] = mk(0, 0, 0,  0, 1, 1, 0,  0, 32'h0);

        fp_tab[0] = mk(1, 1, 1,  9, 1, 1, 0,  0, 32'h0);
        fp_tab[1] = mk(1, 2, 1, 10, 1, 0, 1,  1, 32'h202);
        fp_tab[2] = mk(1, 3, 1, 10, 1, 0, 1,  2, 32'h204);
        fp_tab[3] = mk(1, 4, 1, 10, 1, 0, 1,  3, 32'h208);
        fp_tab[4] = mk(0, 0, 1, 10, 1, 0, 1,  4, 32'h210);
        fp_tab[5] = mk(0, 0, 1, 10, 1, 1, 1,  9, 32'h200);
        fp_tab[6] = mk(0, 0, 1, 11, 1, 1, 1, 10, 32'h400);
        fp_tab[7] = mk(0, 0, 1, 12, 1, 1, 1, 11, 32'h800);
        fp_tab[8] = mk(0, 0, 0,  0, 1, 1, 1, 12, 32'h1000);
        fp_tab[9] = mk(0, 0, 0,  0, 1, 1, 0,  0, 32'h0);

        // Reset with both sources requesting.
        idle_all();
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            av[d] = 1'b1; bv[d] = 1'b1; ard[d] = 5'd3; brd[d] = 5'd4;
        end
        #3;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst%0d_wr_en", d), wen[d], 1'b0);
            chk($sformatf("rst%0d_pend", d), pend[d], 32'h0);
            chk($sformatf("rst%0d_a_ready", d), ar[d], 1'b1);
            chk($sformatf("rst%0d_b_ready", d), br[d], 1'b1);
        end
        @(posedge clk);
        @(negedge clk);
        chk("rst_held_wr_en", wen[0], 1'b0);
        idle_all();
        rst_n = 1'b1;
        next_cycle();

        run_table(0);
        run_table(1);

        // Lone A stream on u_rr: three back-to-back writes one cycle behind acceptance.
        lone_rd[0] = 5'd5; lone_rd[1] = 5'd6; lone_rd[2] = 5'd7;
        lone_dat[0] = 32'h11; lone_dat[1] = 32'h22; lone_dat[2] = 32'h33;
        nwr = 0; first_wr = -1; last_wr = -1;
        for (int c = 0; c < 7; c++) begin
            av[0] = (c < 3);
            ard[0] = (c < 3) ? lone_rd[c] : 5'd0;
            adata[0] = (c < 3) ? lone_dat[c] : 32'h0;
            @(negedge clk);
            sb_check(0, wrote);
            if (wrote) begin
                nwr++;
                if (first_wr < 0) first_wr = c;
                last_wr = c;
            end
            if (c < 3) begin
                chk($sformatf("lone_a_ready_c%0d", c), ar[0], 1'b1);
                sbq.push_back('{rd: lone_rd[c], data: lone_dat[c]});
            end
            next_cycle();
        end
        chk("lone_write_count", nwr, 3);
        chk("lone_first_write_cycle", first_wr, 1);
        chk("lone_last_write_cycle", last_wr, 3);
        chk("lone_sb_empty", sbq.size(), 0);
        idle_all();

        // x0 write: accepted, takes a grant cycle, never enables the port or the mask.
        av[0] = 1'b1; ard[0] = 5'd0; adata[0] = 32'hDEAD;
        @(negedge clk);
        chk("x0_a_ready", ar[0], 1'b1);
        next_cycle();
        av[0] = 1'b0; adata[0] = 32'h0;
        @(negedge clk);
        chk("x0_wr_en", wen[0], 1'b0);
        chk("x0_pend", pend[0], 32'h0);
        chk("x0_slot_data", wdata[0], 32'hDEAD);
        chk("x0_a_ready_granted", ar[0], 1'b1);
        next_cycle();
        @(negedge clk);
        chk("x0_drained", wdata[0], 32'h0);
        chk("x0_wr_en_after", wen[0], 1'b0);
        next_cycle();

        // B rd=8 starved by A on u_fp, then discarded by a mid-cycle reset.
        av[1] = 1'b1; ard[1] = 5'd3; adata[1] = 32'h3;
        bv[1] = 1'b1; brd[1] = 5'd8; bdata[1] = 32'h88;
        @(negedge clk);
        chk("hold_b_accept", br[1], 1'b1);
        next_cycle();
        ard[1] = 5'd4; adata[1] = 32'h4; bv[1] = 1'b0;
        @(negedge clk);
        chk("hold_pend8_c1", pend[1][8], 1'b1);
        chk("hold_wr_rd_c1", wrd[1], 5'd3);
        next_cycle();
        ard[1] = 5'd5; adata[1] = 32'h5;
        @(negedge clk);
        chk("hold_pend8_c2", pend[1][8], 1'b1);
        chk("hold_b_ready_c2", br[1], 1'b0);
        #2;
        bv[1] = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_pend", pend[1], 32'h0);
        chk("midrst_wr_en", wen[1], 1'b0);
        chk("midrst_a_ready", ar[1], 1'b1);
        chk("midrst_b_ready", br[1], 1'b1);
        @(negedge clk);
        idle_all();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            @(negedge clk);
            chk($sformatf("midrst_no_write_c%0d", c), wen[1], 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
